stopwatch_digit_chain: RTL

Parametrised cascaded BCD timer that generalises the single decade hundredths counter into a full multi-digit chain. The default layout is MM:SS.cc.
- Each digit has its own modulus of 10 or 6.
- The chain counts up (stopwatch) or down (countdown with expiry).
- Control covers run/stop, clear and parallel load.
- Sits between the 100 Hz tick prescaler and the 7-segment decode/mux block.

---
 rtl/stopwatch_digit_chain_pkg.sv | 11 +
 rtl/stopwatch_digit_chain_if.sv | 19 +
 rtl/stopwatch_digit_chain_cell.sv | 22 ++
 rtl/stopwatch_digit_chain.sv | 74 +++++++
 4 files changed

// File: rtl/stopwatch_digit_chain_pkg.sv
// stopwatch_pkg: shared state encoding, digit width and modulus helpers for the stopwatch digit chain.
package stopwatch_pkg;
  typedef enum logic [1:0] {STOPPED, RUNNING, EXPIRED} state_t;
  localparam int DIGIT_W = 4;
  function automatic int digit_mod(input logic [31:0] mask, input int i);
    return mask[i] ? 6 : 10;
  endfunction
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] v, input int m);
    return (int'(v) > m - 1) ? DIGIT_W'(m - 1) : v;
  endfunction
endpackage

// File: rtl/stopwatch_digit_chain_if.sv
// stopwatch_digit_chain_if: control and display bus of the digit chain; lap signals exist only with STOPWATCH_LAP_EN.
interface stopwatch_digit_chain_if import stopwatch_pkg::*; #(parameter int DIGITS = 6);
  logic tick, start_stop, clear, load, down;
  logic [DIGIT_W*DIGITS-1:0] load_value, digits;
  logic running, carry_out, done;
`ifdef STOPWATCH_LAP_EN
  logic lap;
  logic [DIGIT_W*DIGITS-1:0] lap_digits;
  modport master(output tick, start_stop, clear, load, down, load_value, lap,
                 input digits, running, carry_out, done, lap_digits);
  modport slave(input tick, start_stop, clear, load, down, load_value, lap,
                output digits, running, carry_out, done, lap_digits);
`else
  modport master(output tick, start_stop, clear, load, down, load_value,
                 input digits, running, carry_out, done);
  modport slave(input tick, start_stop, clear, load, down, load_value,
                output digits, running, carry_out, done);
`endif
endinterface

// File: rtl/stopwatch_digit_chain_cell.sv
// bcd_digit_cell: one BCD digit of configurable modulus with clear > load > count priority.
module bcd_digit_cell import stopwatch_pkg::*; #(parameter int MOD = 10) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               dir,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               clr,
  output logic [DIGIT_W-1:0] q,
  output logic               at_max,
  output logic               at_zero
);
  localparam logic [DIGIT_W-1:0] MAXV = DIGIT_W'(MOD - 1);
  assign at_max = q == MAXV;
  assign at_zero = q == '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (clr) q <= '0;
    else if (load) q <= clamp_digit(load_val, MOD);
    else if (en) q <= dir ? (at_zero ? MAXV : q - 4'd1) : (at_max ? '0 : q + 4'd1);
endmodule

// File: rtl/stopwatch_digit_chain.sv
// stopwatch_digit_chain: cascaded BCD up/down timer with run/stop, clear, load; lap capture via STOPWATCH_LAP_EN.
module stopwatch_digit_chain import stopwatch_pkg::*; #(
  parameter int DIGITS = 6,
  parameter logic [DIGITS-1:0] SEX_MASK = 6'b101000
) (
  input logic clk,
  input logic reset,
  stopwatch_digit_chain_if.slave bus
);
  localparam int W = DIGIT_W * DIGITS;
  state_t state, state_nx;
  logic [1:0] rst_sync;
  logic arst;
  logic [W-1:0] value;
  logic [DIGITS-1:0] at_max, at_zero, en;
  logic ld_e, ss_e, tk_e, cnt_e, all_zero, all_max, running, done, carry;
  always_ff @(posedge clk or posedge reset)
    if (reset) rst_sync <= 2'b11;
    else rst_sync <= {rst_sync[0], 1'b0};
  assign arst = rst_sync[1];
  assign all_zero = &at_zero;
  assign all_max = &at_max;
  assign ld_e = !bus.clear && bus.load && state != RUNNING;
  assign ss_e = !bus.clear && !ld_e && bus.start_stop;
  assign tk_e = !bus.clear && !ss_e && bus.tick && state == RUNNING;
  // a countdown already at zero expires instead of borrowing past it
  assign cnt_e = tk_e && !(bus.down && all_zero);
  always_comb begin
    en[0] = cnt_e;
    for (int k = 1; k < DIGITS; k++) en[k] = en[k-1] && (bus.down ? at_zero[k-1] : at_max[k-1]);
  end
  always_comb
    state_nx = (bus.clear || ld_e) ? STOPPED :
               ss_e ? ((state == STOPPED && !(bus.down && all_zero)) ? RUNNING : STOPPED) :
               (tk_e && bus.down && (all_zero || value == W'(1))) ? EXPIRED : state;
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      state <= STOPPED;
      running <= 1'b0;
      done <= 1'b0;
      carry <= 1'b0;
    end else begin
      state <= state_nx;
      running <= state_nx == RUNNING;
      done <= state_nx == EXPIRED;
      carry <= cnt_e && !bus.down && all_max;
    end
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cell #(.MOD(digit_mod(32'(SEX_MASK), i))) u_cell (
      .clk(clk),
      .reset(arst),
      .en(en[i]),
      .dir(bus.down),
      .load(ld_e),
      .load_val(bus.load_value[DIGIT_W*i +: DIGIT_W]),
      .clr(bus.clear),
      .q(value[DIGIT_W*i +: DIGIT_W]),
      .at_max(at_max[i]),
      .at_zero(at_zero[i])
    );
  end
  assign bus.digits = value;
  assign bus.running = running;
  assign bus.done = done;
  assign bus.carry_out = carry;
`ifdef STOPWATCH_LAP_EN
  logic [W-1:0] lap_q;
  always_ff @(posedge clk or posedge arst)
    if (arst) lap_q <= '0;
    else if (bus.clear) lap_q <= '0;
    else if (bus.lap && state == RUNNING) lap_q <= value;
  assign bus.lap_digits = lap_q;
`endif
endmodule
